// File: rtl/brightness_pkg.sv
// brightness_pkg
//   Shared definitions for the front-panel brightness controller and the
//   brightness stage it drives: FSM state encoding, step direction, level
//   limits, the frame counter type and two small helpers.
package brightness_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PEND     = 3'd1,
        HOLD     = 3'd2,
        REPEAT   = 3'd3,
        BOTH     = 3'd4,
        WAIT_REL = 3'd5
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    typedef logic [3:0] level_t;

    localparam level_t LEVEL_MIN     = 4'd0;
    localparam level_t LEVEL_MAX     = 4'd15;
    localparam level_t LEVEL_DEFAULT = 4'd8;

    typedef logic [7:0] fcnt_t;
    localparam fcnt_t FCNT_MAX = 8'hFF;

    // Frame counter increment that sticks at 255 instead of wrapping.
    function automatic fcnt_t fcnt_step(input fcnt_t c);
        return (c == FCNT_MAX) ? c : c + 8'd1;
    endfunction

    // A step toward a limit the level already sits on is swallowed.
    function automatic logic step_allowed(input dir_t d, input level_t lvl);
        return (d == DIR_UP) ? (lvl != LEVEL_MAX) : (lvl != LEVEL_MIN);
    endfunction

endpackage

// File: rtl/brightness_ctrl_if.sv
// brightness_ctrl_if
//   Link between the panel controller and the brightness stage.
//   level_in  : current level reported by the brightness stage
//   inc/dec   : one-cycle step pulses toward the stage
//   lvl_rst   : one-cycle level-reset request (ORed with rst at the stage)
//   repeating : high while the controller is auto-repeating
//   Handshake: there is no backpressure. inc, dec and lvl_rst are
//   single-cycle strobes that the stage must act on in the cycle they are
//   high; at most one of them is high in any cycle. level_in is sampled
//   only in the cycle a step is issued.
//   master = controller side, slave = brightness stage side.
interface brightness_ctrl_if import brightness_pkg::*; ();
    level_t level_in;
    logic   inc;
    logic   dec;
    logic   lvl_rst;
    logic   repeating;

    modport master (
        input  level_in,
        output inc,
        output dec,
        output lvl_rst,
        output repeating
    );

    modport slave (
        output level_in,
        input  inc,
        input  dec,
        input  lvl_rst,
        input  repeating
    );
endinterface

// File: rtl/brightness_ctrl_key_debounce.sv
// key_debounce
//   2-FF synchronizer plus debouncer for one active-low push-button.
//   clk, rst : system clock, synchronous active-high reset
//   key_n    : raw key, active-low, asynchronous
//   db       : debounced key, active-high (pressed = 1)
//   busy     : synchronized key differs from db (a change is being timed)
//   db follows the synchronized key only after it has differed from db for
//   DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic db,
    output logic busy
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // Invert at the input so everything downstream is pressed = 1.
        meta_d = ~key_n;
        sync_d = meta_q;
        db_d   = db_q;
        cnt_d  = '0;
        if (sync_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign db   = db_q;
    assign busy = (sync_q != db_q);

endmodule

// File: rtl/brightness_ctrl.sv
// brightness_ctrl
//   Front-panel controller: turns two raw push-buttons into inc/dec step
//   pulses and a level-reset pulse, with press-and-hold auto-repeat. All
//   steps are issued on frame boundaries only.
//   clk, rst            : system clock, synchronous active-high reset
//   key_up_n, key_dn_n  : raw keys, active-low, asynchronous
//   vsync               : frame sync, active-high, synchronous to clk
//   bus (master)        : level_in in; inc, dec, lvl_rst, repeating out
//   dbg_state           : current FSM state
//   RESET_HOLD must not exceed 255 (the frame counter saturates there).
module brightness_ctrl
    import brightness_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6,
    parameter int RESET_HOLD   = 120
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_up_n,
    input  logic                     key_dn_n,
    input  logic                     vsync,
    brightness_ctrl_if.master        bus,
    output state_t                   dbg_state
);

    localparam fcnt_t DELAY_F = fcnt_t'(REPEAT_DELAY);
    localparam fcnt_t RATE_F  = fcnt_t'(REPEAT_RATE);
    localparam fcnt_t HOLD_F  = fcnt_t'(RESET_HOLD);

    logic up_db, up_busy;
    logic dn_db, dn_busy;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_up_n),
        .db    (up_db),
        .busy  (up_busy)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_dn_n),
        .db    (dn_db),
        .busy  (dn_busy)
    );

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d;
    fcnt_t       fcnt_q, fcnt_d;
    logic        vsync_q, vsync_d;
    logic        up_prev_q, up_prev_d;
    logic        dn_prev_q, dn_prev_d;
    logic        lock_q, lock_d;
    logic [1:0]  settle_q, settle_d;
    logic        inc_q, inc_d;
    logic        dec_q, dec_d;
    logic        lvl_rst_q, lvl_rst_d;
    logic        repeating_q, repeating_d;

    logic  f;
    logic  up_rise, dn_rise;
    logic  cur_key, oth_key;
    fcnt_t fnext;
    logic  issue;
    logic  rst_pulse;

    assign f       = vsync & ~vsync_q;
    assign up_rise = up_db & ~up_prev_q;
    assign dn_rise = dn_db & ~dn_prev_q;
    assign cur_key = (dir_q == DIR_UP) ? up_db : dn_db;
    assign oth_key = (dir_q == DIR_UP) ? dn_db : up_db;
    assign fnext   = fcnt_step(fcnt_q);

    // Lockout after reset: a key held through reset would otherwise look
    // like a fresh press once its debouncer catches up. The lock clears
    // only after the synchronizers have refilled (settle_q == 2) and both
    // keys are seen stably released.
    always_comb begin
        vsync_d   = vsync;
        up_prev_d = up_db;
        dn_prev_d = dn_db;
        settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        lock_d    = lock_q;
        if (lock_q && (settle_q == 2'd2) && !up_db && !dn_db && !up_busy && !dn_busy) begin
            lock_d = 1'b0;
        end
    end

    // Within each state the checks are ordered release, other-key press,
    // then frame tick, so an earlier condition masks a later one in the
    // same cycle. PEND has no release check: its step is already committed.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        fcnt_d    = fcnt_q;
        issue     = 1'b0;
        rst_pulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (!lock_q) begin
                    if (up_db && dn_db) begin
                        state_d = BOTH;
                    end else if (up_rise) begin
                        state_d = PEND;
                        dir_d   = DIR_UP;
                    end else if (dn_rise) begin
                        state_d = PEND;
                        dir_d   = DIR_DN;
                    end
                end
            end
            PEND: begin
                if (oth_key) begin
                    state_d = BOTH;
                end else if (f) begin
                    issue   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!cur_key) begin
                    state_d = IDLE;
                end else if (oth_key) begin
                    state_d = BOTH;
                end else if (f) begin
                    if (fnext == DELAY_F) begin
                        issue   = 1'b1;
                        state_d = REPEAT;
                    end else begin
                        fcnt_d = fnext;
                    end
                end
            end
            REPEAT: begin
                if (!cur_key) begin
                    state_d = IDLE;
                end else if (oth_key) begin
                    state_d = BOTH;
                end else if (f) begin
                    if (fnext == RATE_F) begin
                        issue  = 1'b1;
                        fcnt_d = '0;
                    end else begin
                        fcnt_d = fnext;
                    end
                end
            end
            BOTH: begin
                if (!up_db || !dn_db) begin
                    state_d = WAIT_REL;
                end else if (f) begin
                    if (fnext == HOLD_F) begin
                        rst_pulse = 1'b1;
                        state_d   = WAIT_REL;
                    end else begin
                        fcnt_d = fnext;
                    end
                end
            end
            WAIT_REL: begin
                if (!up_db && !dn_db) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state entry starts counting frames from zero.
        if (state_d != state_q) begin
            fcnt_d = '0;
        end
    end

    always_comb begin
        inc_d       = issue && (dir_q == DIR_UP) && step_allowed(DIR_UP, bus.level_in);
        dec_d       = issue && (dir_q == DIR_DN) && step_allowed(DIR_DN, bus.level_in);
        lvl_rst_d   = rst_pulse;
        repeating_d = (state_d == REPEAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_UP;
            fcnt_q      <= '0;
            vsync_q     <= 1'b0;
            up_prev_q   <= 1'b0;
            dn_prev_q   <= 1'b0;
            lock_q      <= 1'b1;
            settle_q    <= 2'd0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            lvl_rst_q   <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            fcnt_q      <= fcnt_d;
            vsync_q     <= vsync_d;
            up_prev_q   <= up_prev_d;
            dn_prev_q   <= dn_prev_d;
            lock_q      <= lock_d;
            settle_q    <= settle_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            lvl_rst_q   <= lvl_rst_d;
            repeating_q <= repeating_d;
        end
    end

    assign bus.inc       = inc_q;
    assign bus.dec       = dec_q;
    assign bus.lvl_rst   = lvl_rst_q;
    assign bus.repeating = repeating_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_brightness_ctrl.sv
// tb_brightness_ctrl
//   Directed bench for brightness_ctrl with DEBOUNCE_CYC=4, REPEAT_DELAY=3,
//   REPEAT_RATE=2, RESET_HOLD=5 and a one-cycle vsync every 20 cycles.
//   Frames are numbered relative to the frame in which a key goes down.
module tb_brightness_ctrl;
  import brightness_pkg::*;

  localparam int DB = 4;
  localparam int RD = 3;
  localparam int RR = 2;
  localparam int RH = 5;
  localparam int FP = 20;

  logic   clk = 1'b0;
  logic   rst;
  logic   key_up_n;
  logic   key_dn_n;
  logic   vsync;
  state_t dbg_state;

  brightness_ctrl_if bus_if ();

  brightness_ctrl #(
    .DEBOUNCE_CYC (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .RESET_HOLD   (RH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_up_n  (key_up_n),
    .key_dn_n  (key_dn_n),
    .vsync     (vsync),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ph = FP - 1;
  int frame_no = 0;
  bit vs_en = 1'b0;
  int inc_log[$];
  int dec_log[$];
  int rst_log[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor first (outputs belong to the edge just past, ph is still the
  // cycle that produced them), then advance the frame generator.
  always @(negedge clk) begin
    if (bus_if.inc) begin
      inc_log.push_back(frame_no);
      check("inc_lat", ph, 0);
    end
    if (bus_if.dec) begin
      dec_log.push_back(frame_no);
      check("dec_lat", ph, 0);
    end
    if (bus_if.lvl_rst) begin
      rst_log.push_back(frame_no);
      check("rst_lat", ph, 0);
    end
    check("excl", 32'(bus_if.inc) + 32'(bus_if.dec) + 32'(bus_if.lvl_rst) <= 1 ? 1 : 0, 1);
    if (vs_en) begin
      ph = (ph == FP - 1) ? 0 : ph + 1;
      vsync = (ph == 0);
      if (ph == 0) frame_no++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ph(input int p);
    int n = 0;
    tick();
    while (ph != p && n < 2 * FP) begin
      tick();
      n++;
    end
    if (ph != p) check("wait_ph", ph, p);
  endtask

  task automatic wait_frames(input int k, input int p);
    for (int i = 0; i < k; i++) wait_ph(p);
  endtask

  task automatic clear_logs();
    inc_log.delete();
    dec_log.delete();
    rst_log.delete();
  endtask

  function automatic int rel(input int q[$], input int i, input int base);
    return (i < q.size()) ? q[i] - base : -1;
  endfunction

  // Press one key cleanly at ph 1 of a frame, release at ph 10.
  task automatic tap(input bit up, output int base);
    wait_ph(1);
    base = frame_no;
    clear_logs();
    if (up) key_up_n = 1'b0; else key_dn_n = 1'b0;
    wait_ph(10);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    wait_frames(3, 5);
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    rst = 1'b1;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    vsync = 1'b0;
    bus_if.level_in = LEVEL_DEFAULT;
    repeat (4) tick();
    check("rst_inc", bus_if.inc, 0);
    check("rst_dec", bus_if.dec, 0);
    check("rst_lvl", bus_if.lvl_rst, 0);
    check("rst_rep", bus_if.repeating, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    vs_en = 1'b1;
    wait_frames(2, 1);

    // 1: clean up tap, released before the frame tick
    tap(1'b1, base);
    check("t1_inc_n", inc_log.size(), 1);
    check("t1_inc_frame", rel(inc_log, 0, base), 1);
    check("t1_dec_n", dec_log.size(), 0);
    check("t1_state", dbg_state, IDLE);

    // 2: bouncing down key, then held
    wait_ph(1);
    base = frame_no;
    clear_logs();
    for (int i = 0; i < 30; i++) begin
      key_dn_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    check("t2_bounce_dec", dec_log.size(), 0);
    check("t2_bounce_state", dbg_state, IDLE);
    key_dn_n = 1'b0;
    wait_frames(2, 5);
    check("t2_dec_n", dec_log.size(), 1);
    check("t2_dec_frame", rel(dec_log, 0, base), 2);
    check("t2_inc_n", inc_log.size(), 0);
    key_dn_n = 1'b1;
    wait_frames(2, 5);
    check("t2_state", dbg_state, IDLE);

    // 3: hold up for 12 frames
    wait_ph(1);
    base = frame_no;
    clear_logs();
    exp_q = '{8'd1, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12};
    key_up_n = 1'b0;
    wait_frames(4, 5);
    check("t3_rep_f3", bus_if.repeating, 0);
    wait_ph(5);
    check("t3_rep_f4", bus_if.repeating, 1);
    check("t3_state_f4", dbg_state, REPEAT);
    wait_frames(8, 5);
    key_up_n = 1'b1;
    wait_frames(3, 5);
    check("t3_inc_n", inc_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("t3_inc%0d", i), rel(inc_log, i, base), 32'(exp_q[i]));
    check("t3_rep_end", bus_if.repeating, 0);
    check("t3_state_end", dbg_state, IDLE);

    // 4: hold up at the top level
    bus_if.level_in = LEVEL_MAX;
    wait_ph(1);
    base = frame_no;
    clear_logs();
    key_up_n = 1'b0;
    wait_frames(5, 5);
    check("t4_state", dbg_state, REPEAT);
    wait_frames(3, 5);
    check("t4_inc_n", inc_log.size(), 0);
    check("t4_dec_n", dec_log.size(), 0);
    key_up_n = 1'b1;
    wait_frames(2, 5);
    bus_if.level_in = LEVEL_DEFAULT;
    check("t4_state_end", dbg_state, IDLE);

    // 5: both keys held for 6 frames
    wait_ph(1);
    base = frame_no;
    clear_logs();
    key_up_n = 1'b0;
    key_dn_n = 1'b0;
    wait_frames(2, 10);
    check("t5_both", dbg_state, BOTH);
    wait_frames(5, 5);
    check("t5_rst_n", rst_log.size(), 1);
    check("t5_rst_frame", rel(rst_log, 0, base), 5);
    check("t5_inc_n", inc_log.size(), 0);
    check("t5_dec_n", dec_log.size(), 0);
    check("t5_wait", dbg_state, WAIT_REL);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    wait_frames(2, 5);
    check("t5_rst_n_end", rst_log.size(), 1);
    check("t5_state_end", dbg_state, IDLE);

    // 6: rst pulse while repeating, key kept down
    wait_ph(1);
    base = frame_no;
    clear_logs();
    key_up_n = 1'b0;
    wait_frames(6, 5);
    check("t6_state_pre", dbg_state, REPEAT);
    check("t6_inc_pre", inc_log.size(), 2);
    clear_logs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_inc", bus_if.inc, 0);
    check("t6_rep", bus_if.repeating, 0);
    check("t6_state", dbg_state, IDLE);
    wait_frames(5, 5);
    check("t6_inc_held", inc_log.size(), 0);
    check("t6_state_held", dbg_state, IDLE);
    key_up_n = 1'b1;
    wait_frames(2, 5);

    // 7: a fresh press after the reset works again
    tap(1'b1, base);
    check("t7_inc_n", inc_log.size(), 1);
    check("t7_inc_frame", rel(inc_log, 0, base), 1);

    // 8: down at the bottom level is swallowed, down at the top is not
    bus_if.level_in = LEVEL_MIN;
    tap(1'b0, base);
    check("t8_dec_min", dec_log.size(), 0);
    bus_if.level_in = LEVEL_MAX;
    tap(1'b0, base);
    check("t8_dec_max", dec_log.size(), 1);
    check("t8_dec_frame", rel(dec_log, 0, base), 1);
    bus_if.level_in = LEVEL_DEFAULT;

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
